// File: rtl/debug_pkg.sv
// debug_pkg: state encodings and compare-mode codes shared by the debug trigger unit.
//   ST_*   : 2-bit trigger FSM states (IDLE / HOLDOFF / ARMED / FIRED)
//   MODE_* : 2-bit compare modes (LEVEL / ENTER / EXIT / CHANGE)
package debug_pkg;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_HOLDOFF = 2'b01;
    localparam logic [1:0] ST_ARMED   = 2'b10;
    localparam logic [1:0] ST_FIRED   = 2'b11;

    localparam logic [1:0] MODE_LEVEL  = 2'b00;
    localparam logic [1:0] MODE_ENTER  = 2'b01;
    localparam logic [1:0] MODE_EXIT   = 2'b10;
    localparam logic [1:0] MODE_CHANGE = 2'b11;

endpackage

// File: rtl/debug_trg_match.sv
// debug_trg_match: masked compare of the probed bus plus the previous-sample history used by the edge modes.
//   clk, rst : clock, asynchronous active-high reset
//   en       : sample enable; history registers only move when high
//   clr      : invalidates the history (arm edge or auto re-arm); the current sample is still stored
//   mode     : LEVEL / ENTER / EXIT / CHANGE
//   data_in  : probed bus
//   pattern  : compare value
//   mask     : 1 = bit participates in the compare
//   cond     : selected trigger condition for the current sample (combinational)
module debug_trg_match
    import debug_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] pattern,
    input  logic [WIDTH-1:0] mask,
    output logic             cond
);

    logic [WIDTH-1:0] prev_q, prev_d;
    logic             prev_m_q, prev_m_d;
    logic             prev_v_q, prev_v_d;
    logic             match, changed;

    // Kept as separate continuous assigns so cond has no combinational dependence on clr.
    assign match   = ((data_in ^ pattern) & mask) == '0;
    assign changed = ((data_in ^ prev_q) & mask) != '0;
    assign cond    = (mode == MODE_LEVEL) ? match :
                     (mode == MODE_ENTER) ? (match & ~prev_m_q & prev_v_q) :
                     (mode == MODE_EXIT)  ? (~match & prev_m_q & prev_v_q) :
                                            (changed & prev_v_q);

    always_comb begin
        prev_d   = en ? data_in : prev_q;
        prev_m_d = en ? match : prev_m_q;
        prev_v_d = clr ? 1'b0 : (en | prev_v_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q   <= '0;
            prev_m_q <= 1'b0;
            prev_v_q <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            prev_m_q <= prev_m_d;
            prev_v_q <= prev_v_d;
        end
    end

endmodule

// File: rtl/debug_trigger_unit.sv
// debug_trigger_unit: produces the single-cycle trg pulse that starts a Debug_SHR capture.
//   clk, rst : clock, asynchronous active-high reset
//   en       : sample enable; low freezes everything except arm edge capture, trg forced 0
//   arm      : level; rising edge arms / re-arms (pending while en=0)
//   data_in  : probed bus, pattern / mask : masked compare value, mode : LEVEL/ENTER/EXIT/CHANGE
//   holdoff  : enabled cycles to wait after arm before a trigger is allowed, latched on the arm edge
//   trg      : registered one-cycle trigger pulse
//   armed    : state == ARMED, fired : state == FIRED
//   trg_cnt  : saturating count of triggers since reset
// Optional feature macro DBG_TRG_AUTO_REARM_EN: FIRED re-enters HOLDOFF after RE_LEN enabled cycles.
module debug_trigger_unit
    import debug_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int HOLD_BITS = 8,
    parameter int CNT_BITS  = 8,
    parameter int RE_LEN    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 arm,
    input  logic [WIDTH-1:0]     data_in,
    input  logic [WIDTH-1:0]     pattern,
    input  logic [WIDTH-1:0]     mask,
    input  logic [1:0]           mode,
    input  logic [HOLD_BITS-1:0] holdoff,
    output logic                 trg,
    output logic                 armed,
    output logic                 fired,
    output logic [CNT_BITS-1:0]  trg_cnt
);

    logic [1:0]           state_q, state_d;
    logic [HOLD_BITS-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_BITS-1:0]  trg_cnt_q, trg_cnt_d;
    logic                 trg_q, trg_d;
    logic                 arm_q, pend_q, pend_d;
    logic                 arm_edge, arm_ev, rearm, cond;

`ifdef DBG_TRG_AUTO_REARM_EN
    localparam int RE_BITS = $clog2(RE_LEN + 1);
    logic [HOLD_BITS-1:0] hold_lat_q, hold_lat_d;
    logic [RE_BITS-1:0]   re_cnt_q, re_cnt_d;
`endif

    debug_trg_match #(.WIDTH(WIDTH)) u_match (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clr     (arm_ev | rearm),
        .mode    (mode),
        .data_in (data_in),
        .pattern (pattern),
        .mask    (mask),
        .cond    (cond)
    );

    always_comb begin
        arm_edge   = arm & ~arm_q;
        // An edge seen while frozen is remembered and acted on at the next enabled cycle.
        arm_ev     = en & (arm_edge | pend_q);
        pend_d     = ~en & (pend_q | arm_edge);
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        trg_d      = 1'b0;
        rearm      = 1'b0;
`ifdef DBG_TRG_AUTO_REARM_EN
        hold_lat_d = hold_lat_q;
        re_cnt_d   = re_cnt_q;
`endif
        // The arm edge is checked first so it beats a coincident trigger condition.
        if (arm_ev) begin
            state_d    = (holdoff == '0) ? ST_ARMED : ST_HOLDOFF;
            hold_cnt_d = holdoff;
`ifdef DBG_TRG_AUTO_REARM_EN
            hold_lat_d = holdoff;
`endif
        end else if (en) begin
            if (state_q == ST_HOLDOFF) begin
                // A zero count (auto re-arm with holdoff 0) still spends one cycle here.
                hold_cnt_d = (hold_cnt_q <= HOLD_BITS'(1)) ? '0 : hold_cnt_q - 1'b1;
                state_d    = (hold_cnt_q <= HOLD_BITS'(1)) ? ST_ARMED : ST_HOLDOFF;
            end else if (state_q == ST_ARMED && cond) begin
                state_d = ST_FIRED;
                trg_d   = 1'b1;
`ifdef DBG_TRG_AUTO_REARM_EN
                re_cnt_d = RE_BITS'(RE_LEN);
`endif
            end
`ifdef DBG_TRG_AUTO_REARM_EN
            else if (state_q == ST_FIRED) begin
                // Wait out the capture window, then restart from the last latched holdoff.
                rearm      = re_cnt_q <= RE_BITS'(1);
                re_cnt_d   = rearm ? '0 : re_cnt_q - 1'b1;
                state_d    = rearm ? ST_HOLDOFF : ST_FIRED;
                hold_cnt_d = rearm ? hold_lat_q : hold_cnt_q;
            end
`endif
        end
        trg_cnt_d = (trg_d && trg_cnt_q != '1) ? trg_cnt_q + 1'b1 : trg_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            trg_cnt_q  <= '0;
            trg_q      <= 1'b0;
            arm_q      <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            trg_cnt_q  <= trg_cnt_d;
            trg_q      <= trg_d;
            arm_q      <= arm;
            pend_q     <= pend_d;
        end
    end

`ifdef DBG_TRG_AUTO_REARM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_lat_q <= '0;
            re_cnt_q   <= '0;
        end else begin
            hold_lat_q <= hold_lat_d;
            re_cnt_q   <= re_cnt_d;
        end
    end
`endif

    assign trg     = trg_q;
    assign armed   = state_q == ST_ARMED;
    assign fired   = state_q == ST_FIRED;
    assign trg_cnt = trg_cnt_q;

endmodule

// File: tb/tb_debug_trigger_unit.sv
// tb_debug_trigger_unit: directed scenarios plus randomized traffic checked against a behavioural model.
module tb_debug_trigger_unit;

    localparam int RL = 16;
    localparam int S_IDLE = 0, S_HOLD = 1, S_ARMED = 2, S_FIRED = 3;

    logic       clk = 1'b0;
    logic       rst, en, arm;
    logic [7:0] data_in, pattern, mask, holdoff;
    logic [1:0] mode;
    logic       trg, armed, fired;
    logic [7:0] trg_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    int         m_st, m_wait, m_re, m_lat, m_cnt;
    bit         m_trg, m_last_arm, m_pend, m_pv, m_pm;
    logic [7:0] m_prev;

    debug_trigger_unit #(.WIDTH(8), .HOLD_BITS(8), .CNT_BITS(8), .RE_LEN(RL)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .arm     (arm),
        .data_in (data_in),
        .pattern (pattern),
        .mask    (mask),
        .mode    (mode),
        .holdoff (holdoff),
        .trg     (trg),
        .armed   (armed),
        .fired   (fired),
        .trg_cnt (trg_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit is_match(logic [7:0] d, logic [7:0] p, logic [7:0] k);
        for (int i = 0; i < 8; i++)
            if (k[i] && d[i] != p[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_reset();
        m_st = S_IDLE; m_wait = 0; m_re = 0; m_lat = 0; m_cnt = 0;
        m_trg = 0; m_last_arm = 0; m_pend = 0; m_pv = 0; m_pm = 0; m_prev = 8'h00;
    endtask

    // One clock of the reference behaviour, evaluated on the inputs the DUT is about to sample.
    task automatic model_step();
        bit edge_now, act, mt, c, re;
        edge_now   = arm && !m_last_arm;
        m_last_arm = arm;
        m_trg      = 0;
        if (!en) begin
            m_pend = m_pend || edge_now;
            return;
        end
        act    = edge_now || m_pend;
        m_pend = 0;
        re     = 0;
        mt     = is_match(data_in, pattern, mask);
        case (mode)
            2'd0:    c = mt;
            2'd1:    c = mt && !m_pm && m_pv;
            2'd2:    c = !mt && m_pm && m_pv;
            default: c = m_pv && !is_match(data_in, m_prev, mask);
        endcase
        if (act) begin
            m_lat = int'(holdoff);
            if (holdoff == 0) m_st = S_ARMED;
            else begin m_st = S_HOLD; m_wait = int'(holdoff); end
        end else if (m_st == S_HOLD) begin
            m_wait--;
            if (m_wait <= 0) m_st = S_ARMED;
        end else if (m_st == S_ARMED && c) begin
            m_st  = S_FIRED;
            m_trg = 1;
            if (m_cnt < 255) m_cnt++;
            m_re  = RL;
        end
`ifdef DBG_TRG_AUTO_REARM_EN
        else if (m_st == S_FIRED) begin
            m_re--;
            if (m_re == 0) begin
                re     = 1;
                m_st   = S_HOLD;
                m_wait = (m_lat > 0) ? m_lat : 1;
            end
        end
`endif
        m_prev = data_in;
        m_pm   = mt;
        m_pv   = !(act || re);
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; arm = 1'b0; data_in = 8'h00; pattern = 8'h00;
        mask = 8'h00; mode = 2'd0; holdoff = 8'h00;
        m_reset();
        #1;
        n_cmp++;
        if (trg !== 1'b0 || armed !== 1'b0 || fired !== 1'b0 || trg_cnt !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_async: trg=%b armed=%b fired=%b cnt=%h, required all zero", trg, armed, fired, trg_cnt);
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (trg !== 1'b0 || armed !== 1'b0 || fired !== 1'b0 || trg_cnt !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_held: trg=%b armed=%b fired=%b cnt=%h, required all zero", trg, armed, fired, trg_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_level();
        do_reset();
        mode = 2'd0; mask = 8'hFF; pattern = 8'hA5; holdoff = 8'h00; data_in = 8'h00; en = 1'b1; arm = 1'b0;
        cyc();
        arm = 1'b1;
        cyc();
        n_cmp++;
        if (armed !== 1'b1 || trg !== 1'b0) begin
            n_bad++;
            $display("FAIL level_armed: armed=%b trg=%b, required armed=1 trg=0", armed, trg);
        end
        cyc();
        n_cmp++;
        if (trg !== 1'b0) begin
            n_bad++;
            $display("FAIL level_nomatch: trg=%b, required 0", trg);
        end
        data_in = 8'hA5;
        cyc();
        n_cmp++;
        if (trg !== 1'b1 || fired !== 1'b1 || trg_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL level_fire: trg=%b fired=%b cnt=%0d, required 1 1 1", trg, fired, trg_cnt);
        end
        data_in = 8'h00;
        cyc();
        n_cmp++;
        if (trg !== 1'b0 || fired !== 1'b1 || trg_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL level_single_pulse: trg=%b fired=%b cnt=%0d, required 0 1 1", trg, fired, trg_cnt);
        end
    endtask

    task automatic test_enter();
        int seen = 0;
        do_reset();
        mode = 2'd1; pattern = 8'h0F; mask = 8'h0F; data_in = 8'h3F; holdoff = 8'h00; en = 1'b1; arm = 1'b0;
        cyc();
        arm = 1'b1;
        cyc();
        repeat (3) begin
            cyc();
            seen += int'(trg);
        end
        data_in = 8'h30;
        cyc();
        seen += int'(trg);
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL enter_held_match: %0d pulses, required 0", seen);
        end
        data_in = 8'h1F;
        cyc();
        n_cmp++;
        if (trg !== 1'b1 || trg_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL enter_fire: trg=%b cnt=%0d, required 1 1", trg, trg_cnt);
        end
        seen = 0;
        data_in = 8'h30; cyc(); seen += int'(trg);
        data_in = 8'h1F; cyc(); seen += int'(trg);
        n_cmp++;
        if (seen != 0 || trg_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL enter_once: %0d extra pulses cnt=%0d, required 0 and 1", seen, trg_cnt);
        end
    endtask

    task automatic test_holdoff();
        int n;
        do_reset();
        mode = 2'd0; mask = 8'h00; holdoff = 8'd5; en = 1'b1; arm = 1'b0; data_in = 8'h12;
        cyc();
        arm = 1'b1;
        cyc();
        n = 0;
        while (trg !== 1'b1 && n < 30) begin
            cyc();
            n++;
            if (n == 2) begin
                n_cmp++;
                if (armed !== 1'b0 || fired !== 1'b0) begin
                    n_bad++;
                    $display("FAIL holdoff_state: armed=%b fired=%b, required 0 0", armed, fired);
                end
            end
        end
        n_cmp++;
        if (n != 6) begin
            n_bad++;
            $display("FAIL holdoff_latency: trg after %0d cycles, required 6", n);
        end
        arm = 1'b0;
        cyc();
        arm = 1'b1;
        cyc();
        cyc(); cyc();
        en = 1'b0;
        repeat (3) cyc();
        en = 1'b1;
        n = 5;
        while (trg !== 1'b1 && n < 30) begin
            cyc();
            n++;
        end
        n_cmp++;
        if (n != 9) begin
            n_bad++;
            $display("FAIL holdoff_stretch: trg after %0d cycles, required 9", n);
        end
    endtask

    task automatic test_change();
        int seen = 0;
        do_reset();
        mode = 2'd3; mask = 8'h01; holdoff = 8'h00; data_in = 8'h00; en = 1'b1; arm = 1'b0;
        cyc();
        arm = 1'b1;
        cyc();
        repeat (6) begin
            data_in ^= 8'h80;
            cyc();
            seen += int'(trg);
        end
        n_cmp++;
        if (seen != 0 || armed !== 1'b1) begin
            n_bad++;
            $display("FAIL change_masked_bit: %0d pulses armed=%b, required 0 and 1", seen, armed);
        end
        data_in ^= 8'h01;
        cyc();
        n_cmp++;
        if (trg !== 1'b1) begin
            n_bad++;
            $display("FAIL change_fire: trg=%b, required 1", trg);
        end
        arm = 1'b0; cyc();
        arm = 1'b1; cyc();
        arm = 1'b0; cyc();
        arm = 1'b1; holdoff = 8'd3; data_in ^= 8'h01;
        cyc();
        n_cmp++;
        if (trg !== 1'b0 || armed !== 1'b0 || fired !== 1'b0 || trg_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL change_arm_wins: trg=%b armed=%b fired=%b cnt=%0d, required 0 0 0 1", trg, armed, fired, trg_cnt);
        end
        repeat (3) cyc();
        n_cmp++;
        if (armed !== 1'b1 || trg !== 1'b0) begin
            n_bad++;
            $display("FAIL change_rearmed: armed=%b trg=%b, required 1 0", armed, trg);
        end
    endtask

    task automatic test_saturate();
        int missing = 0;
        do_reset();
        mode = 2'd0; mask = 8'h00; holdoff = 8'h00; en = 1'b1; arm = 1'b0;
        cyc();
        for (int i = 1; i <= 257; i++) begin
            arm = 1'b1; cyc();
            arm = 1'b0; cyc();
            if (trg !== 1'b1) missing++;
            if (i == 254) begin
                n_cmp++;
                if (trg_cnt !== 8'hFE) begin
                    n_bad++;
                    $display("FAIL sat_254: cnt=%h, required fe", trg_cnt);
                end
            end
        end
        n_cmp++;
        if (missing != 0 || trg_cnt !== 8'hFF) begin
            n_bad++;
            $display("FAIL sat_hold: missing=%0d cnt=%h, required 0 and ff", missing, trg_cnt);
        end
        mode = 2'd1;
        arm = 1'b1; cyc();
        cyc(); cyc();
        n_cmp++;
        if (armed !== 1'b1 || trg_cnt !== 8'hFF) begin
            n_bad++;
            $display("FAIL sat_armed: armed=%b cnt=%h, required 1 ff", armed, trg_cnt);
        end
        #3 rst = 1'b1;
        #1;
        n_cmp++;
        if (trg !== 1'b0 || armed !== 1'b0 || fired !== 1'b0 || trg_cnt !== 8'h00) begin
            n_bad++;
            $display("FAIL rst_midop: trg=%b armed=%b fired=%b cnt=%h, required all zero", trg, armed, fired, trg_cnt);
        end
        m_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        arm = 1'b0;
    endtask

    task automatic test_auto_rearm();
        int cnt = 0, last = 0, bad_gap = 0;
        do_reset();
        mode = 2'd0; mask = 8'h00; holdoff = 8'h00; en = 1'b1; arm = 1'b0;
        cyc();
        arm = 1'b1;
        cyc();
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (trg === 1'b1) begin
                if (cnt > 0 && i - last != 18) bad_gap++;
                last = i;
                cnt++;
            end
        end
`ifdef DBG_TRG_AUTO_REARM_EN
        n_cmp++;
        if (cnt != 4 || bad_gap != 0) begin
            n_bad++;
            $display("FAIL auto_rearm_period: %0d pulses %0d bad gaps, required 4 and 0", cnt, bad_gap);
        end
`else
        n_cmp++;
        if (cnt != 1) begin
            n_bad++;
            $display("FAIL fired_terminal: %0d pulses, required 1", cnt);
        end
`endif
    endtask

    task automatic test_random();
        do_reset();
        en = 1'b1; arm = 1'b0; mode = 2'd0; pattern = 8'h5A; mask = 8'hF0; holdoff = 8'd2; data_in = 8'h00;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                mode    = 2'($urandom);
                pattern = 8'($urandom);
                mask    = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            end
            if ($urandom_range(0, 14) == 0) arm = ~arm;
            holdoff = 8'($urandom_range(0, 4));
            en      = $urandom_range(0, 5) != 0;
            data_in = ($urandom_range(0, 3) == 0) ? pattern : (data_in ^ 8'(1 << $urandom_range(0, 7)));
            cyc();
            n_cmp++;
            if (trg !== m_trg || armed !== (m_st == S_ARMED) || fired !== (m_st == S_FIRED) || trg_cnt !== 8'(m_cnt)) begin
                n_bad++;
                $display("FAIL random_cycle_%0d: trg=%b armed=%b fired=%b cnt=%0d, required %b %b %b %0d",
                         i, trg, armed, fired, trg_cnt, m_trg, m_st == S_ARMED, m_st == S_FIRED, m_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_level();
        test_enter();
        test_holdoff();
        test_change();
        test_saturate();
        test_auto_rearm();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
